// File: rtl/muxn_pkg.sv
// Shared types for the N-channel streaming multiplexer.
package muxn_pkg;

    // Selection policy. The encoding 2'b11 is not named and behaves as MODE_PRI.
    typedef enum logic [1:0] {
        MODE_MAN = 2'b00,
        MODE_PRI = 2'b01,
        MODE_RR  = 2'b10
    } mode_t;

    // Arbitration state: free to pick, or locked to one channel until its packet ends.
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Next channel index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/muxn_stream_rr_pick.sv
// Find-first-set over req, starting the search at ptr and wrapping modulo N.
module rr_pick
    import muxn_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    // Walk the channels in rotated order; the first requester seen wins.
    always_comb begin : search
        logic [N-1:0]  gnt_v;
        logic          any_v;
        logic [SW-1:0] idx_v;
        logic          hit_v;
        gnt_v = {N{1'b0}};
        any_v = 1'b0;
        idx_v = {SW{1'b0}};
        hit_v = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_v        = SW'((int'(ptr) + k) % N);
            hit_v        = req[idx_v] & ~any_v;
            gnt_v[idx_v] = gnt_v[idx_v] | hit_v;
            any_v        = any_v | hit_v;
        end
        gnt = gnt_v;
        any = any_v;
    end

endmodule

// File: rtl/muxn_stream.sv
// N-channel valid/ready multiplexer with packet locking and a registered output stage.
module muxn_stream
    import muxn_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic            out_last,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    input  logic            out_ready
);

    state_t        state_r, state_n_s;
    logic [SW-1:0] owner_r, owner_n_s;
    logic [SW-1:0] ptr_r, ptr_n_s;
    logic          out_valid_r, out_last_r;
    logic [W-1:0]  out_data_r;
    logic [SW-1:0] out_ch_r;

    mode_t         mode_s;
    logic          adv_s;
    logic [SW-1:0] pick_ptr_s;
    logic [N-1:0]  pick_gnt_s;
    logic          pick_any_s;
    logic [N-1:0]  grant_s;
    logic          xfer_s;
    logic [W-1:0]  xfer_data_s;
    logic          xfer_last_s;
    logic [SW-1:0] xfer_idx_s;

    assign mode_s     = mode_t'(mode);
    // The output stage can accept a new beat when empty or being drained this edge.
    assign adv_s      = ~out_valid_r | out_ready;
    // Fixed priority is round-robin search anchored at channel 0.
    assign pick_ptr_s = (mode_s == MODE_RR) ? ptr_r : {SW{1'b0}};

    rr_pick #(.N(N)) u_pick (
        .req (in_valid),
        .ptr (pick_ptr_s),
        .gnt (pick_gnt_s),
        .any (pick_any_s)
    );

    // One-hot grant: the lock owner while mid-packet, otherwise the mode's choice.
    always_comb begin
        grant_s = {N{1'b0}};
        case (state_r)
            ST_LOCK: grant_s[owner_r] = 1'b1;
            ST_ARB: begin
                case (mode_s)
                    MODE_MAN: begin
                        if (int'(sel) < N) begin
                            grant_s[sel] = in_valid[sel];
                        end else begin
                            grant_s = {N{1'b0}};
                        end
                    end
                    default: grant_s = pick_any_s ? pick_gnt_s : {N{1'b0}};
                endcase
            end
            default: grant_s = {N{1'b0}};
        endcase
    end

    assign in_ready = {N{adv_s}} & grant_s;
    assign xfer_s   = |(in_valid & in_ready);

    // AND-OR mux of the granted channel's payload and its index.
    always_comb begin : payload_mux
        logic [W-1:0]  d_v;
        logic          l_v;
        logic [SW-1:0] i_v;
        d_v = {W{1'b0}};
        l_v = 1'b0;
        i_v = {SW{1'b0}};
        for (int i = 0; i < N; i++) begin
            d_v = d_v | (in_data[i*W +: W] & {W{grant_s[i]}});
            l_v = l_v | (in_last[i] & grant_s[i]);
            i_v = i_v | (SW'(i) & {SW{grant_s[i]}});
        end
        xfer_data_s = d_v;
        xfer_last_s = l_v;
        xfer_idx_s  = i_v;
    end

    // Next lock state, owner and round-robin pointer from the accepted beat.
    always_comb begin
        state_n_s = state_r;
        owner_n_s = owner_r;
        ptr_n_s   = ptr_r;
        if (xfer_s) begin
            if (xfer_last_s) begin
                state_n_s = ST_ARB;
                ptr_n_s   = SW'(wrap_inc(int'(xfer_idx_s), N));
            end else begin
                state_n_s = ST_LOCK;
                owner_n_s = xfer_idx_s;
            end
        end else begin
            state_n_s = state_r;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_ARB;
            owner_r <= {SW{1'b0}};
            ptr_r   <= {SW{1'b0}};
        end else begin
            state_r <= state_n_s;
            owner_r <= owner_n_s;
            ptr_r   <= ptr_n_s;
        end
    end

    // Output stage: load on transfer, empty on an idle advance, hold under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_ch_r    <= {SW{1'b0}};
        end else if (adv_s) begin
            out_valid_r <= xfer_s;
            if (xfer_s) begin
                out_last_r <= xfer_last_s;
                out_data_r <= xfer_data_s;
                out_ch_r   <= xfer_idx_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_muxn_stream.sv
// Scoreboard bench for muxn_stream: randomized and directed traffic against a behavioural model.
module tb_muxn_stream;
    import muxn_pkg::*;

    localparam int N = 4, W = 8, SW = 2;
    localparam int N2 = 6, W2 = 4, SW2 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]     mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid, in_last, in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_last, out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;

    logic [1:0]       mode2;
    logic [SW2-1:0]   sel2;
    logic [N2-1:0]    in_valid2, in_last2, in_ready2;
    logic [N2*W2-1:0] in_data2;
    logic             out_valid2, out_last2, out_ready2;
    logic [W2-1:0]    out_data2;
    logic [SW2-1:0]   out_ch2;

    muxn_stream #(.N(N), .W(W)) dut (
        .clk(clk), .reset(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    // Six channels so that select values beyond the last channel are expressible.
    muxn_stream #(.N(N2), .W(W2)) dut2 (
        .clk(clk), .reset(rst), .mode(mode2), .sel(sel2),
        .in_valid(in_valid2), .in_last(in_last2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_last(out_last2), .out_data(out_data2), .out_ch(out_ch2),
        .out_ready(out_ready2)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           ch;
    } item_t;

    item_t exp_q[$];
    int    ch_log[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model state: packet lock and the round-robin start channel.
    bit m_locked;
    int m_owner;
    int m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name, input int e[$]);
        check({name, " length"}, ch_log.size(), e.size());
        for (int i = 0; i < e.size() && i < ch_log.size(); i++) begin
            check(name, ch_log[i], e[i]);
        end
    endtask

    // Which channel the selection rules pick for the current inputs, -1 for none.
    function automatic int model_grant();
        if (m_locked) return m_owner;
        case (mode)
            2'b00: begin
                if (int'(sel) < N && in_valid[sel]) return int'(sel);
                return -1;
            end
            2'b10: begin
                for (int k = 0; k < N; k++) begin
                    if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
                end
            end
            default: begin
                for (int c = 0; c < N; c++) begin
                    if (in_valid[c]) return c;
                end
            end
        endcase
        return -1;
    endfunction

    // Drive one cycle of stimulus, check in_ready, and predict what gets loaded.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*W-1:0] d,
                         input logic [1:0] md, input logic [SW-1:0] s, input logic ordy);
        int           g;
        bit           adv, xf;
        logic [N-1:0] exp_rdy;
        item_t        it;
        @(negedge clk);
        in_valid = v; in_last = l; in_data = d; mode = md; sel = s; out_ready = ordy;
        #1;
        adv     = (exp_q.size() == 0) || ordy;
        g       = model_grant();
        exp_rdy = '0;
        if (adv && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", in_ready & in_valid, exp_rdy & in_valid);
        xf = adv && (g >= 0) && in_valid[g];
        @(posedge clk);
        #1;
        if (xf) begin
            it.data = d[g*W +: W];
            it.last = l[g];
            it.ch   = g;
            exp_q.push_back(it);
            if (l[g]) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
            end
        end
    endtask

    task automatic drain();
        repeat (3) cycle('0, '0, '0, 2'b01, '0, 1'b1);
    endtask

    // Monitor: just before each rising edge, compare the presented beat and retire consumed ones.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                check("out_valid", out_valid, exp_q.size() != 0);
                if (out_valid && exp_q.size() != 0) begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_last", out_last, exp_q[0].last);
                    check("out_ch", out_ch, exp_q[0].ch);
                    if (out_ready) begin
                        ch_log.push_back(int'(out_ch));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int e[$];
        logic [N-1:0] rv, rl;
        rst = 1'b1;
        mode = 2'b00; sel = '0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        mode2 = 2'b00; sel2 = '0; in_valid2 = '0; in_last2 = '0; in_data2 = '0; out_ready2 = 1'b1;
        m_locked = 1'b0; m_owner = 0; m_ptr = 0;

        #12;
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_last", out_last, 1'b0);
        check("reset out_data", out_data, '0);
        check("reset out_ch", out_ch, '0);
        check("reset dut2 out_valid", out_valid2, 1'b0);
        #1 rst = 1'b0;

        // Round-robin, every channel valid, single-beat packets.
        ch_log.delete();
        repeat (5) cycle(4'hF, 4'hF, $urandom, MODE_RR, '0, 1'b1);
        drain();
        e = '{0, 1, 2, 3, 0};
        check_seq("rr_seq", e);

        // Packet lock in fixed priority: channel 1 holds the output while channel 0 waits.
        ch_log.delete();
        cycle(4'b0010, 4'b0000, $urandom, MODE_PRI, '0, 1'b1);
        cycle(4'b0011, 4'b0001, $urandom, MODE_PRI, '0, 1'b1);
        cycle(4'b0011, 4'b0011, $urandom, MODE_PRI, '0, 1'b1);
        cycle(4'b0011, 4'b0011, $urandom, MODE_PRI, '0, 1'b1);
        drain();
        e = '{1, 1, 1, 0};
        check_seq("lock_seq", e);

        // Backpressure for four cycles, then release with a new beat waiting.
        ch_log.delete();
        cycle(4'b0010, 4'b0010, $urandom, MODE_PRI, '0, 1'b1);
        repeat (4) cycle(4'hF, 4'hF, $urandom, MODE_PRI, '0, 1'b0);
        cycle(4'hF, 4'hF, $urandom, MODE_PRI, '0, 1'b1);
        drain();
        e = '{1, 0};
        check_seq("bp_seq", e);

        // Manual select.
        ch_log.delete();
        cycle(4'b1000, 4'b1000, $urandom, MODE_MAN, 2'd3, 1'b1);
        cycle(4'b1111, 4'b1111, $urandom, MODE_MAN, 2'd3, 1'b1);
        cycle(4'b1101, 4'b1111, $urandom, MODE_MAN, 2'd1, 1'b1);
        drain();
        e = '{3, 3};
        check_seq("man_seq", e);

        // Mode and select changes while locked are ignored until the last beat.
        ch_log.delete();
        cycle(4'b0001, 4'b0000, $urandom, MODE_MAN, 2'd0, 1'b1);
        cycle(4'b0101, 4'b0100, $urandom, MODE_RR,  2'd2, 1'b1);
        cycle(4'b0101, 4'b0101, $urandom, MODE_MAN, 2'd2, 1'b1);
        cycle(4'b0101, 4'b0101, $urandom, MODE_MAN, 2'd2, 1'b1);
        drain();
        e = '{0, 0, 0, 2};
        check_seq("lockchg_seq", e);

        // Out-of-range select on the six-channel instance grants nothing.
        @(negedge clk);
        in_valid2 = 6'b111111; in_last2 = 6'b111111; in_data2 = 24'h654321;
        mode2 = 2'b00; sel2 = 3'd2; out_ready2 = 1'b1;
        #1 check("dut2 sel2 in_ready", in_ready2, 6'b000100);
        @(posedge clk); #1;
        check("dut2 sel2 out_valid", out_valid2, 1'b1);
        check("dut2 sel2 out_ch", out_ch2, 3'd2);
        check("dut2 sel2 out_data", out_data2, 4'h3);
        @(negedge clk); sel2 = 3'd6;
        #1 check("dut2 sel6 in_ready", in_ready2, 6'b000000);
        @(posedge clk); #1;
        check("dut2 sel6 drained", out_valid2, 1'b0);
        @(negedge clk); sel2 = 3'd7;
        #1 check("dut2 sel7 in_ready", in_ready2, 6'b000000);
        @(posedge clk); #1;
        check("dut2 sel7 out_valid", out_valid2, 1'b0);
        @(negedge clk); in_valid2 = '0;

        // Randomized traffic across all modes, with backpressure.
        for (int n = 0; n < 400; n++) begin
            rv = 4'($urandom_range(0, 15));
            for (int b = 0; b < N; b++) rl[b] = ($urandom_range(0, 2) == 0);
            cycle(rv, rl, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0));
        end
        drain();

        // Reset in the middle of a three-beat packet on channel 2.
        cycle(4'b0100, 4'b0000, 32'h00AB0000, MODE_PRI, '0, 1'b1);
        cycle(4'b0100, 4'b0000, 32'h00CD0000, MODE_PRI, '0, 1'b0);
        #1;
        rst = 1'b1;
        in_valid = '0;
        #1;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset out_last", out_last, 1'b0);
        check("midreset out_data", out_data, '0);
        check("midreset out_ch", out_ch, '0);
        exp_q.delete();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0;
        @(negedge clk);
        #1 rst = 1'b0;
        ch_log.delete();
        cycle(4'b0101, 4'b0101, $urandom, MODE_PRI, '0, 1'b1);
        drain();
        e = '{0};
        check_seq("postreset_seq", e);

        check("final queue empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
